img_proc_frame_ctrl: RTL and testbench

- Frame-synchronous controller for the grayscale/Sobel image-processing pipeline.
- Accepts filter-mode requests from a debounced push-button and from a direct register write.
- Holds each request pending and applies it only at a frame boundary, so a frame is never rendered in mixed modes.
- Sequences the pipeline per frame (run, drain, switch), pulses a line-buffer flush between frames and counts completed frames. Sits between the camera/CCD timing logic and the processing module.

---
 rtl/img_proc_pkg.sv | 26 ++
 rtl/img_proc_frame_ctrl_key_debounce.sv | 49 ++++
 rtl/img_proc_frame_ctrl.sv | 137 +++++++++++++
 tb/tb_img_proc_frame_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_proc_pkg.sv
// Shared types for the image-processing frame controller: filter modes and
// the per-frame sequencing states.
package img_proc_pkg;

    typedef enum logic [1:0] {
        MODE_GRAY = 2'd0,
        MODE_GX   = 2'd1,
        MODE_GY   = 2'd2,
        MODE_MAG  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        SWITCH = 2'd3
    } ctrl_state_t;

    // Next mode in the push-button cycle, wrapping MODE_MAG back to MODE_GRAY.
    function automatic mode_t mode_step(input mode_t m);
        logic [1:0] v;
        v = m + 2'd1;
        return mode_t'(v);
    endfunction

endpackage

// File: rtl/img_proc_frame_ctrl_key_debounce.sv
// Push-button debouncer: two-flop synchroniser, stability counter and a
// one-cycle press pulse on each accepted release-to-press transition.
module key_debounce
    import img_proc_pkg::*;
#(
    parameter int DEB_CYCLES = 50000
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iKEY_n,
    output logic oPRESS
);

    localparam int            CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= iKEY_n;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            // Any return to the stable level restarts the qualification window.
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
                press_q  <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign oPRESS = press_q;

endmodule

// File: rtl/img_proc_frame_ctrl.sv
// Frame-synchronous mode controller: sequences the pipeline per frame and
// applies pending filter-mode requests only at frame boundaries.
//
//   state  | meaning
//   IDLE   | waiting for a frame to start
//   RUN    | frame active, pipeline enabled by pixel valid
//   DRAIN  | frame ended, pipeline forced on to flush the window stages
//   SWITCH | one cycle: flush pulse, pending mode applied, frame counted
module img_proc_frame_ctrl
    import img_proc_pkg::*;
#(
    parameter int DEB_CYCLES   = 50000,
    parameter int DRAIN_CYCLES = 8,
    parameter int CNT_W        = 16
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iFVAL,
    input  logic             iDVAL,
    input  logic             iKEY_n,
    input  logic             iMODE_WR,
    input  logic [1:0]       iMODE_REQ,
    output logic [1:0]       oMODE,
    output logic             oEn,
    output logic             oPIPE_EN,
    output logic             oFLUSH,
    output logic             oPENDING,
    output logic             oOVERRUN,
    output logic [CNT_W-1:0] oFRAME_CNT
);

    localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    ctrl_state_t      state_q;
    mode_t            mode_q;
    mode_t            pend_mode_q;
    logic             pend_q;
    logic             en_q;
    logic             flush_q;
    logic             overrun_q;
    logic             start_pend_q;
    logic             fval_q;
    logic [DW-1:0]    drain_q;
    logic [CNT_W-1:0] frame_cnt_q;

    logic  press;
    logic  rise;
    logic  fall;
    mode_t press_base;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iKEY_n (iKEY_n),
        .oPRESS (press)
    );

    assign rise       = iFVAL & ~fval_q;
    assign fall       = ~iFVAL & fval_q;
    assign press_base = pend_q ? pend_mode_q : mode_q;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q      <= IDLE;
            mode_q       <= MODE_GRAY;
            pend_mode_q  <= MODE_GRAY;
            pend_q       <= 1'b0;
            en_q         <= 1'b0;
            flush_q      <= 1'b0;
            overrun_q    <= 1'b0;
            start_pend_q <= 1'b0;
            fval_q       <= 1'b0;
            drain_q      <= '0;
            frame_cnt_q  <= '0;
        end else begin
            fval_q  <= iFVAL;
            flush_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) state_q <= RUN;
                end
                RUN: begin
                    if (fall) begin
                        drain_q <= DRAIN_LOAD;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rise) begin
                        start_pend_q <= 1'b1;
                        overrun_q    <= 1'b1;
                    end
                    if (drain_q == '0) begin
                        state_q <= SWITCH;
                        flush_q <= 1'b1;
                    end else begin
                        drain_q <= drain_q - DW'(1);
                    end
                end
                SWITCH: begin
                    if (rise) overrun_q <= 1'b1;
                    if (pend_q) begin
                        mode_q <= pend_mode_q;
                        en_q   <= (pend_mode_q == MODE_GX);
                        pend_q <= 1'b0;
                    end
                    frame_cnt_q  <= frame_cnt_q + CNT_W'(1);
                    start_pend_q <= 1'b0;
                    // A frame that started during drain/switch goes straight back to RUN.
                    state_q      <= (start_pend_q | rise) ? RUN : IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Placed after the FSM so a request in the SWITCH cycle re-arms pending.
            if (iMODE_WR) begin
                pend_mode_q <= mode_t'(iMODE_REQ);
                pend_q      <= 1'b1;
            end else if (press) begin
                pend_mode_q <= mode_step(press_base);
                pend_q      <= 1'b1;
            end
        end
    end

    assign oMODE      = mode_q;
    assign oEn        = en_q;
    assign oPIPE_EN   = ((state_q == RUN) & iDVAL) | (state_q == DRAIN);
    assign oFLUSH     = flush_q;
    assign oPENDING   = pend_q;
    assign oOVERRUN   = overrun_q;
    assign oFRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_img_proc_frame_ctrl.sv
// Self-checking bench for img_proc_frame_ctrl: a reference mode/counter model
// pushes expected boundary results; a monitor pops them after each flush.
`timescale 1ns/1ps
module tb_img_proc_frame_ctrl;
    import img_proc_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fval = 1'b0;
    logic          dval = 1'b0;
    logic          key_n = 1'b1;
    logic          wr = 1'b0;
    logic [1:0]    req = 2'd0;
    logic [1:0]    mode;
    logic          en, pipe_en, flush, pending, overrun;
    logic [CW-1:0] fcnt;

    int n_chk = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]    mode;
        logic [CW-1:0] cnt;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    logic [1:0]    m_mode = 2'd0;
    logic [1:0]    m_pmode = 2'd0;
    logic          m_pend = 1'b0;
    logic [CW-1:0] m_cnt = '0;
    bit            post_sw = 1'b0;

    always #5 clk = ~clk;

    img_proc_frame_ctrl #(
        .DEB_CYCLES   (4),
        .DRAIN_CYCLES (3),
        .CNT_W        (CW)
    ) dut (
        .iCLK       (clk),
        .iRST       (rst_n),
        .iFVAL      (fval),
        .iDVAL      (dval),
        .iKEY_n     (key_n),
        .iMODE_WR   (wr),
        .iMODE_REQ  (req),
        .oMODE      (mode),
        .oEn        (en),
        .oPIPE_EN   (pipe_en),
        .oFLUSH     (flush),
        .oPENDING   (pending),
        .oOVERRUN   (overrun),
        .oFRAME_CNT (fcnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Boundary results are compared one cycle after the flush pulse.
    always @(negedge clk) begin
        if (post_sw && rst_n) begin
            chk("sb_avail", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("sb_mode", mode, mon_e.mode);
                chk("sb_en", en, mon_e.mode == MODE_GX);
                chk("sb_cnt", fcnt, mon_e.cnt);
            end
        end
        post_sw = rst_n && flush;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_start();
        fval = 1'b1;
        step();
    endtask

    task automatic frame_body(input int n);
        for (int i = 0; i < n; i++) begin
            dval = i[0];
            @(negedge clk);
            chk("pipe_en_run", pipe_en, dval);
            step();
        end
        dval = 1'b0;
    endtask

    task automatic boundary();
        exp_t e;
        if (m_pend) m_mode = m_pmode;
        m_pend = 1'b0;
        m_cnt  = m_cnt + 1'b1;
        e.mode = m_mode;
        e.cnt  = m_cnt;
        sb_q.push_back(e);
    endtask

    task automatic frame_end(input bit detail);
        bit seen;
        seen = 1'b0;
        boundary();
        fval = 1'b0;
        dval = 1'b0;
        if (detail) begin
            for (int k = 0; k < 3; k++) begin
                step();
                @(negedge clk);
                chk("pipe_en_drain", pipe_en, 1);
                chk("flush_drain", flush, 0);
            end
            step();
            @(negedge clk);
            chk("flush_switch", flush, 1);
            chk("pipe_en_switch", pipe_en, 0);
        end else begin
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (flush) seen = 1'b1;
            end
            chk("flush_timeout", seen, 1);
        end
        step();
        step();
    endtask

    task automatic do_wr(input logic [1:0] v);
        req = v;
        wr  = 1'b1;
        step();
        wr  = 1'b0;
        m_pmode = v;
        m_pend  = 1'b1;
    endtask

    task automatic do_press();
        key_n = 1'b0;
        step(10);
        key_n = 1'b1;
        step(10);
        m_pmode = (m_pend ? m_pmode : m_mode) + 2'd1;
        m_pend  = 1'b1;
    endtask

    initial begin
        bit seen;
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        step(3);
        rst_n = 1'b1;
        step(2);
        @(negedge clk);
        chk("rst_mode", mode, 0);
        chk("rst_en", en, 0);
        chk("rst_pend", pending, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_cnt", fcnt, 0);
        chk("rst_flush", flush, 0);
        chk("rst_pipe", pipe_en, 0);
        step();

        // Plain frame with detailed drain/flush timing.
        frame_start();
        frame_body(20);
        frame_end(1);

        // Direct write mid-frame held until the boundary.
        frame_start();
        frame_body(5);
        do_wr(2'd2);
        @(negedge clk);
        chk("pend_after_wr", pending, 1);
        chk("mode_hold", mode, 0);
        step();
        frame_body(5);
        frame_end(0);
        @(negedge clk);
        chk("pend_cleared", pending, 0);
        step();

        // Mode 1, then two presses in one frame accumulate to 3.
        frame_start();
        do_wr(2'd1);
        frame_end(0);
        frame_start();
        do_press();
        do_press();
        @(negedge clk);
        chk("pend_press", pending, 1);
        chk("mode_before_b", mode, 1);
        step();
        frame_end(0);

        // Two-cycle glitch is rejected.
        frame_start();
        key_n = 1'b0;
        step(2);
        key_n = 1'b1;
        step(12);
        @(negedge clk);
        chk("glitch_pend", pending, 0);
        step();
        frame_end(0);

        // Write and press in the same cycle: write wins.
        frame_start();
        do_wr(2'd0);
        frame_end(0);
        frame_start();
        key_n = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (dut.u_deb.oPRESS) seen = 1'b1;
        end
        chk("press_seen", seen, 1);
        req = 2'd1;
        wr  = 1'b1;
        step();
        wr  = 1'b0;
        m_pmode = 2'd1;
        m_pend  = 1'b1;
        key_n = 1'b1;
        step(10);
        frame_end(0);

        // Frame starts during the second drain cycle.
        frame_start();
        frame_body(4);
        boundary();
        fval = 1'b0;
        step();
        step();
        fval = 1'b1;
        dval = 1'b1;
        step();
        @(negedge clk);
        chk("overrun_set", overrun, 1);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (flush) seen = 1'b1;
        end
        chk("ovr_flush", seen, 1);
        step();
        @(negedge clk);
        chk("run_after_sw", pipe_en, 1);
        step();
        frame_body(6);
        frame_end(0);
        chk("overrun_sticky", overrun, 1);

        // Counter wrap.
        while (m_cnt != 4'hF) begin
            frame_start();
            frame_body(2);
            frame_end(0);
        end
        frame_start();
        frame_body(2);
        frame_end(0);
        chk("cnt_wrap", fcnt, 0);
        frame_start();
        frame_body(2);
        frame_end(0);

        // Asynchronous reset mid-RUN.
        frame_start();
        do_wr(2'd3);
        dval = 1'b1;
        step(2);
        @(negedge clk);
        chk("pre_rst_pipe", pipe_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mode", mode, 0);
        chk("arst_en", en, 0);
        chk("arst_pend", pending, 0);
        chk("arst_ovr", overrun, 0);
        chk("arst_cnt", fcnt, 0);
        chk("arst_flush", flush, 0);
        chk("arst_pipe", pipe_en, 0);
        fval = 1'b0;
        dval = 1'b0;
        m_mode = 2'd0;
        m_pend = 1'b0;
        m_cnt  = '0;
        sb_q.delete();
        step(2);
        rst_n = 1'b1;
        step(2);
        frame_start();
        frame_body(4);
        frame_end(0);
        step(3);
        chk("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
